// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with round-robin tie breaking.
// Requests are sampled only in IDLE. Writes take one memory cycle.
// Reads wait for m_ReadReady, or abort with ERR_DATA after TIMEOUT RD cycles.
// Every memory-side and requester-side output comes straight from a register.
module mem_arbiter #(
    parameter logic [7:0]  TIMEOUT  = 8'd200,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        r0_ReadValid,
    input  logic        r0_WriteValid,
    input  logic [31:0] r0_Addr,
    input  logic [31:0] r0_WriteData,
    output logic        r0_ReadReady,
    output logic        r0_WriteDone,
    output logic [31:0] r0_ReadData,
    input  logic        r1_ReadValid,
    input  logic        r1_WriteValid,
    input  logic [31:0] r1_Addr,
    input  logic [31:0] r1_WriteData,
    output logic        r1_ReadReady,
    output logic        r1_WriteDone,
    output logic [31:0] r1_ReadData,
    output logic        m_ReadValid,
    output logic        m_WriteValid,
    output logic [31:0] m_Addr,
    output logic [31:0] m_WriteData,
    input  logic        m_ReadReady,
    input  logic [31:0] m_ReadData,
    output logic        Busy,
    output logic        Grant,
    output logic        TimeoutErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        last_grant_q;
    logic        grant_q;
    logic        op_wr_q;
    logic        busy_q;
    logic        timeout_err_q;
    logic        m_rvalid_q;
    logic        m_wvalid_q;
    logic [31:0] m_addr_q;
    logic [31:0] m_wdata_q;
    logic        r0_rready_q;
    logic        r0_wdone_q;
    logic [31:0] r0_rdata_q;
    logic        r1_rready_q;
    logic        r1_wdone_q;
    logic [31:0] r1_rdata_q;

    logic        req0_s;
    logic        req1_s;
    logic        valid_d;
    logic        grant_d;
    logic        wr_d;
    logic [31:0] addr_d;
    logic [31:0] wdata_d;

    // Arbitration: pick the winner and its operation from the live request lines.
    always_comb begin
        req0_s  = r0_ReadValid | r0_WriteValid;
        req1_s  = r1_ReadValid | r1_WriteValid;
        valid_d = req0_s | req1_s;
        grant_d = 1'b0;
        wr_d    = 1'b0;
        addr_d  = 32'h0;
        wdata_d = 32'h0;
        if (req0_s && req1_s) begin
            grant_d = ~last_grant_q;
        end else if (req1_s) begin
            grant_d = 1'b1;
        end else begin
            grant_d = 1'b0;
        end
        // A request with both flags set is treated as a write.
        if (grant_d) begin
            wr_d    = r1_WriteValid;
            addr_d  = r1_Addr;
            wdata_d = r1_WriteData;
        end else begin
            wr_d    = r0_WriteValid;
            addr_d  = r0_Addr;
            wdata_d = r0_WriteData;
        end
    end

    // Transaction FSM; all outputs are registered alongside the state.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            last_grant_q  <= 1'b1;
            grant_q       <= 1'b0;
            op_wr_q       <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            m_rvalid_q    <= 1'b0;
            m_wvalid_q    <= 1'b0;
            m_addr_q      <= 32'h0;
            m_wdata_q     <= 32'h0;
            r0_rready_q   <= 1'b0;
            r0_wdone_q    <= 1'b0;
            r0_rdata_q    <= 32'h0;
            r1_rready_q   <= 1'b0;
            r1_wdone_q    <= 1'b0;
            r1_rdata_q    <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_d) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        op_wr_q      <= wr_d;
                        m_addr_q     <= addr_d;
                        m_wdata_q    <= wdata_d;
                        busy_q       <= 1'b1;
                        cnt_q        <= 8'd0;
                        if (wr_d) begin
                            m_wvalid_q <= 1'b1;
                            state_q    <= WR;
                        end else begin
                            m_rvalid_q <= 1'b1;
                            state_q    <= RD;
                        end
                    end
                end
                WR: begin
                    m_wvalid_q <= 1'b0;
                    r0_wdone_q <= ~grant_q;
                    r1_wdone_q <= grant_q;
                    state_q    <= DONE;
                end
                RD: begin
                    // Ready beats timeout when both land in the same cycle.
                    if (m_ReadReady || (cnt_q == (TIMEOUT - 8'd1))) begin
                        m_rvalid_q    <= 1'b0;
                        timeout_err_q <= ~m_ReadReady;
                        r0_rready_q   <= ~grant_q;
                        r1_rready_q   <= grant_q;
                        if (grant_q) begin
                            r1_rdata_q <= m_ReadReady ? m_ReadData : ERR_DATA;
                        end else begin
                            r0_rdata_q <= m_ReadReady ? m_ReadData : ERR_DATA;
                        end
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    r0_rready_q   <= 1'b0;
                    r0_wdone_q    <= 1'b0;
                    r1_rready_q   <= 1'b0;
                    r1_wdone_q    <= 1'b0;
                    timeout_err_q <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign r0_ReadReady = r0_rready_q;
    assign r0_WriteDone = r0_wdone_q;
    assign r0_ReadData  = r0_rdata_q;
    assign r1_ReadReady = r1_rready_q;
    assign r1_WriteDone = r1_wdone_q;
    assign r1_ReadData  = r1_rdata_q;
    assign m_ReadValid  = m_rvalid_q;
    assign m_WriteValid = m_wvalid_q;
    assign m_Addr       = m_addr_q;
    assign m_WriteData  = m_wdata_q;
    assign Busy         = busy_q;
    assign Grant        = grant_q;
    assign TimeoutErr   = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=5): writes, reads, timeout,
// round robin, write-over-read priority and reset during a read.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        r0_ReadValid, r0_WriteValid;
    logic [31:0] r0_Addr, r0_WriteData;
    logic        r0_ReadReady, r0_WriteDone;
    logic [31:0] r0_ReadData;
    logic        r1_ReadValid, r1_WriteValid;
    logic [31:0] r1_Addr, r1_WriteData;
    logic        r1_ReadReady, r1_WriteDone;
    logic [31:0] r1_ReadData;
    logic        m_ReadValid, m_WriteValid;
    logic [31:0] m_Addr, m_WriteData;
    logic        m_ReadReady;
    logic [31:0] m_ReadData;
    logic        Busy, Grant, TimeoutErr;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.TIMEOUT(8'd5), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .CLK(CLK), .Reset(Reset),
        .r0_ReadValid(r0_ReadValid), .r0_WriteValid(r0_WriteValid),
        .r0_Addr(r0_Addr), .r0_WriteData(r0_WriteData),
        .r0_ReadReady(r0_ReadReady), .r0_WriteDone(r0_WriteDone),
        .r0_ReadData(r0_ReadData),
        .r1_ReadValid(r1_ReadValid), .r1_WriteValid(r1_WriteValid),
        .r1_Addr(r1_Addr), .r1_WriteData(r1_WriteData),
        .r1_ReadReady(r1_ReadReady), .r1_WriteDone(r1_WriteDone),
        .r1_ReadData(r1_ReadData),
        .m_ReadValid(m_ReadValid), .m_WriteValid(m_WriteValid),
        .m_Addr(m_Addr), .m_WriteData(m_WriteData),
        .m_ReadReady(m_ReadReady), .m_ReadData(m_ReadData),
        .Busy(Busy), .Grant(Grant), .TimeoutErr(TimeoutErr)
    );

    // 10 ns clock.
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Directed stimulus; inputs change 1 ns after each rising edge.
    initial begin
        Reset = 1'b1;
        r0_ReadValid = 1'b0; r0_WriteValid = 1'b0; r0_Addr = 32'h0; r0_WriteData = 32'h0;
        r1_ReadValid = 1'b0; r1_WriteValid = 1'b0; r1_Addr = 32'h0; r1_WriteData = 32'h0;
        m_ReadReady = 1'b0; m_ReadData = 32'h0;
        tick(); tick();
        chk("rst_busy", {31'h0, Busy}, 32'h0);
        chk("rst_mrv", {31'h0, m_ReadValid}, 32'h0);
        chk("rst_mwv", {31'h0, m_WriteValid}, 32'h0);
        chk("rst_addr", m_Addr, 32'h0);
        chk("rst_grant", {31'h0, Grant}, 32'h0);
        chk("rst_terr", {31'h0, TimeoutErr}, 32'h0);
        chk("rst_r0data", r0_ReadData, 32'h0);
        Reset = 1'b0;

        // Single write from r0.
        r0_WriteValid = 1'b1; r0_Addr = 32'h0000_0010; r0_WriteData = 32'hA5A5_0001;
        tick();
        chk("wr_mwv", {31'h0, m_WriteValid}, 32'h1);
        chk("wr_addr", m_Addr, 32'h0000_0010);
        chk("wr_data", m_WriteData, 32'hA5A5_0001);
        chk("wr_busy", {31'h0, Busy}, 32'h1);
        chk("wr_grant", {31'h0, Grant}, 32'h0);
        chk("wr_done_early", {31'h0, r0_WriteDone}, 32'h0);
        tick();
        chk("wr_mwv_drop", {31'h0, m_WriteValid}, 32'h0);
        chk("wr_done", {31'h0, r0_WriteDone}, 32'h1);
        chk("wr_done_r1", {31'h0, r1_WriteDone}, 32'h0);
        chk("wr_busy_done", {31'h0, Busy}, 32'h1);
        r0_WriteValid = 1'b0;
        tick();
        chk("wr_idle_busy", {31'h0, Busy}, 32'h0);
        chk("wr_done_clr", {31'h0, r0_WriteDone}, 32'h0);

        // r1 read, memory ready on the fourth RD cycle.
        r1_ReadValid = 1'b1; r1_Addr = 32'h0000_0200;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("rd_mrv", {31'h0, m_ReadValid}, 32'h1);
            chk("rd_addr", m_Addr, 32'h0000_0200);
            chk("rd_r1rr_wait", {31'h0, r1_ReadReady}, 32'h0);
        end
        chk("rd_grant", {31'h0, Grant}, 32'h1);
        m_ReadReady = 1'b1; m_ReadData = 32'h1234_5678;
        tick();
        chk("rd_r1rr", {31'h0, r1_ReadReady}, 32'h1);
        chk("rd_r1data", r1_ReadData, 32'h1234_5678);
        chk("rd_r0rr", {31'h0, r0_ReadReady}, 32'h0);
        chk("rd_terr", {31'h0, TimeoutErr}, 32'h0);
        chk("rd_mrv_drop", {31'h0, m_ReadValid}, 32'h0);
        m_ReadReady = 1'b0; m_ReadData = 32'h0; r1_ReadValid = 1'b0;
        tick();
        chk("rd_r1rr_clr", {31'h0, r1_ReadReady}, 32'h0);
        chk("rd_r1data_hold", r1_ReadData, 32'h1234_5678);
        chk("rd_idle_busy", {31'h0, Busy}, 32'h0);

        // r0 read that times out after five RD cycles.
        r0_ReadValid = 1'b1; r0_Addr = 32'h0000_0300;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("to_mrv", {31'h0, m_ReadValid}, 32'h1);
            chk("to_r0rr_wait", {31'h0, r0_ReadReady}, 32'h0);
            chk("to_terr_wait", {31'h0, TimeoutErr}, 32'h0);
        end
        tick();
        chk("to_r0rr", {31'h0, r0_ReadReady}, 32'h1);
        chk("to_r0data", r0_ReadData, 32'hDEAD_BEEF);
        chk("to_terr", {31'h0, TimeoutErr}, 32'h1);
        r0_ReadValid = 1'b0;
        tick();
        chk("to_terr_clr", {31'h0, TimeoutErr}, 32'h0);

        // Ready arriving on the fifth RD cycle wins over the timeout.
        r0_ReadValid = 1'b1; r0_Addr = 32'h0000_0304;
        for (int i = 1; i <= 5; i++) begin
            tick();
        end
        chk("rt_mrv", {31'h0, m_ReadValid}, 32'h1);
        m_ReadReady = 1'b1; m_ReadData = 32'hCAFE_0005;
        tick();
        chk("rt_r0rr", {31'h0, r0_ReadReady}, 32'h1);
        chk("rt_r0data", r0_ReadData, 32'hCAFE_0005);
        chk("rt_terr", {31'h0, TimeoutErr}, 32'h0);
        m_ReadReady = 1'b0; m_ReadData = 32'h0; r0_ReadValid = 1'b0;
        tick();

        // Read and write both set: write only.
        r0_ReadValid = 1'b1; r0_WriteValid = 1'b1; r0_Addr = 32'h0000_0040; r0_WriteData = 32'h0000_0040;
        tick();
        chk("rw_mwv", {31'h0, m_WriteValid}, 32'h1);
        chk("rw_mrv", {31'h0, m_ReadValid}, 32'h0);
        tick();
        chk("rw_wdone", {31'h0, r0_WriteDone}, 32'h1);
        chk("rw_rready", {31'h0, r0_ReadReady}, 32'h0);
        r0_ReadValid = 1'b0; r0_WriteValid = 1'b0;
        tick();

        // Round robin after reset with both requesting continuously.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        r0_WriteValid = 1'b1; r0_Addr = 32'h0000_00A0; r0_WriteData = 32'h0000_00A0;
        r1_WriteValid = 1'b1; r1_Addr = 32'h0000_00B0; r1_WriteData = 32'h0000_00B0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_grant", {31'h0, Grant}, (k % 2 == 1) ? 32'h1 : 32'h0);
            chk("rr_addr", m_Addr, (k % 2 == 1) ? 32'h0000_00B0 : 32'h0000_00A0);
            tick();
            chk("rr_r0done", {31'h0, r0_WriteDone}, (k % 2 == 1) ? 32'h0 : 32'h1);
            chk("rr_r1done", {31'h0, r1_WriteDone}, (k % 2 == 1) ? 32'h1 : 32'h0);
            tick();
        end
        r0_WriteValid = 1'b0; r1_WriteValid = 1'b0;
        tick();

        // Reset in the middle of a read.
        r1_ReadValid = 1'b1; r1_Addr = 32'h0000_0500;
        tick(); tick();
        chk("rr_rd_grant", {31'h0, Grant}, 32'h1);
        Reset = 1'b1;
        tick();
        chk("rs_busy", {31'h0, Busy}, 32'h0);
        chk("rs_mrv", {31'h0, m_ReadValid}, 32'h0);
        chk("rs_addr", m_Addr, 32'h0);
        chk("rs_grant", {31'h0, Grant}, 32'h0);
        chk("rs_r1rr", {31'h0, r1_ReadReady}, 32'h0);
        chk("rs_r1data", r1_ReadData, 32'h0);
        Reset = 1'b0;
        r0_WriteValid = 1'b1; r0_Addr = 32'h0000_0600; r0_WriteData = 32'h0000_0600;
        tick();
        chk("rs_tie_grant", {31'h0, Grant}, 32'h0);
        chk("rs_tie_mwv", {31'h0, m_WriteValid}, 32'h1);
        chk("rs_tie_addr", m_Addr, 32'h0000_0600);
        chk("rs_no_r1rr", {31'h0, r1_ReadReady}, 32'h0);
        r0_WriteValid = 1'b0; r1_ReadValid = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
